// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and width defaults for the two-client memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 28;
    localparam int unsigned LINE_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        CLIENT_I = 1'b0,
        CLIENT_D = 1'b1
    } client_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin next-grant selection; pick is only meaningful when a request is present.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic    req_i,
    input  logic    req_d,
    input  client_e last_grant,
    output client_e pick
);

    always_comb begin
        pick = CLIENT_I;
        if (req_i && req_d) begin
            pick = (last_grant == CLIENT_I) ? CLIENT_D : CLIENT_I;
        end else if (req_d) begin
            pick = CLIENT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction- and data-cache line requests onto one shared memory port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              proc_reset,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_e state_q, state_d;
    client_e    last_grant_q, last_grant_d;
    client_e    pick;
    logic       i_req, d_req;

    assign i_req   = i_read | i_write;
    assign d_req   = d_read | d_write;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    rr_pick2 u_pick (
        .req_i      (i_req),
        .req_d      (d_req),
        .last_grant (last_grant_q),
        .pick       (pick)
    );

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q      <= IDLE;
            last_grant_q <= CLIENT_D;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Ready is masked during reset so an abandoned transaction never completes.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        i_ready      = 1'b0;
        d_ready      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d      = (pick == CLIENT_I) ? GRANT_I : GRANT_D;
                    last_grant_d = pick;
                end
            end
            GRANT_I: begin
                mem_addr  = i_addr;
                mem_wdata = i_wdata;
                mem_write = i_write;
                mem_read  = i_read & ~i_write;
                if (!i_req) begin
                    state_d = IDLE;
                end else begin
                    i_ready = mem_ready & ~proc_reset;
                    if (mem_ready) state_d = IDLE;
                end
            end
            GRANT_D: begin
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_write = d_write;
                mem_read  = d_read & ~d_write;
                if (!d_req) begin
                    state_d = IDLE;
                end else begin
                    d_ready = mem_ready & ~proc_reset;
                    if (mem_ready) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

    localparam int unsigned AW = 28;
    localparam int unsigned LW = 128;

    logic          clk = 1'b0;
    logic          proc_reset;
    logic          i_read, i_write, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [LW-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic          i_ready, d_ready, mem_read, mem_write, mem_ready;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [LW-1:0] PAT_A5 = {16{8'hA5}};

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .i_read     (i_read),
        .i_write    (i_write),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .i_rdata    (i_rdata),
        .i_ready    (i_ready),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and land 1ns after it; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_mrd"}, LW'(mem_read), '0);
        check_eq({tag, "_mwr"}, LW'(mem_write), '0);
        check_eq({tag, "_maddr"}, LW'(mem_addr), '0);
        check_eq({tag, "_mwdata"}, mem_wdata, '0);
        check_eq({tag, "_irdy"}, LW'(i_ready), '0);
        check_eq({tag, "_drdy"}, LW'(d_ready), '0);
    endtask

    initial begin
        proc_reset = 1'b1;
        i_read = 1'b1; i_write = 1'b0; i_addr = 28'h0000010; i_wdata = 128'h77;
        d_read = 1'b0; d_write = 1'b0; d_addr = 28'h0000030; d_wdata = 128'h88;
        mem_rdata = PAT_A5; mem_ready = 1'b1;

        // Reset holds IDLE outputs even with a request and mem_ready present
        step(); step();
        settle();
        check_idle("reset");
        i_read = 1'b0; mem_ready = 1'b0; proc_reset = 1'b0;

        // I-only read: one-cycle arbitration latency, then mem_ready after 3 cycles
        step();
        i_read = 1'b1;
        settle();
        check_eq("i_rd_lat_mrd", LW'(mem_read), '0);
        step(); settle();
        check_eq("i_rd_mrd", LW'(mem_read), 1);
        check_eq("i_rd_maddr", LW'(mem_addr), 28'h0000010);
        check_eq("i_rd_mwr", LW'(mem_write), '0);
        step(); step();
        check_eq("i_rd_wait_irdy", LW'(i_ready), '0);
        mem_ready = 1'b1;
        settle();
        check_eq("i_rd_irdy", LW'(i_ready), 1);
        check_eq("i_rd_rdata", i_rdata, PAT_A5);
        check_eq("i_rd_drdy", LW'(d_ready), '0);
        step();
        mem_ready = 1'b0; i_read = 1'b0;
        settle();
        check_eq("i_rd_done_irdy", LW'(i_ready), '0);
        check_eq("i_rd_done_mrd", LW'(mem_read), '0);

        // Tie after reset goes to I, then alternates
        proc_reset = 1'b1;
        step();
        proc_reset = 1'b0;
        i_addr = 28'h0000020; i_read = 1'b1; d_read = 1'b1;
        step(); settle();
        check_eq("tie1_maddr", LW'(mem_addr), 28'h0000020);
        mem_ready = 1'b1;
        settle();
        check_eq("tie1_irdy", LW'(i_ready), 1);
        check_eq("tie1_drdy", LW'(d_ready), '0);
        step();
        mem_ready = 1'b0; i_read = 1'b0;
        settle();
        check_eq("tie1_gap_mrd", LW'(mem_read), '0);
        step(); settle();
        check_eq("tie1_d_maddr", LW'(mem_addr), 28'h0000030);
        check_eq("tie1_d_mrd", LW'(mem_read), 1);
        mem_ready = 1'b1;
        settle();
        check_eq("tie1_d_drdy", LW'(d_ready), 1);
        check_eq("tie1_d_irdy", LW'(i_ready), '0);
        step();
        mem_ready = 1'b0; i_read = 1'b1;
        step(); settle();
        check_eq("tie2_maddr", LW'(mem_addr), 28'h0000020);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step(); settle();
        check_eq("tie3_maddr", LW'(mem_addr), 28'h0000030);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0; i_read = 1'b0; d_read = 1'b0;
        step();

        // D write-back, I read, D fill with gap cycles between each
        d_write = 1'b1; d_addr = 28'h0000123; d_wdata = 128'h1;
        step(); settle();
        check_eq("wb_mwr", LW'(mem_write), 1);
        check_eq("wb_mrd", LW'(mem_read), '0);
        check_eq("wb_maddr", LW'(mem_addr), 28'h0000123);
        check_eq("wb_mwdata", mem_wdata, 128'h1);
        i_read = 1'b1; i_addr = 28'h0000456; i_wdata = 128'hDEAD;
        settle();
        check_eq("wb_iso_maddr", LW'(mem_addr), 28'h0000123);
        check_eq("wb_iso_mwdata", mem_wdata, 128'h1);
        mem_ready = 1'b1;
        settle();
        check_eq("wb_drdy", LW'(d_ready), 1);
        step();
        mem_ready = 1'b0; d_write = 1'b0; d_read = 1'b1;
        settle();
        check_eq("wb_gap_mwr", LW'(mem_write), '0);
        check_eq("wb_gap_mrd", LW'(mem_read), '0);
        step(); settle();
        check_eq("ird_maddr", LW'(mem_addr), 28'h0000456);
        check_eq("ird_mrd", LW'(mem_read), 1);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0; i_read = 1'b0;
        settle();
        check_eq("ird_gap_mrd", LW'(mem_read), '0);
        step(); settle();
        check_eq("fill_maddr", LW'(mem_addr), 28'h0000123);
        check_eq("fill_mrd", LW'(mem_read), 1);
        check_eq("fill_mwr", LW'(mem_write), '0);

        // Reset during GRANT_D with mem_ready in the same cycle
        proc_reset = 1'b1; mem_ready = 1'b1;
        settle();
        check_eq("rst_mid_drdy", LW'(d_ready), '0);
        step();
        proc_reset = 1'b0;
        settle();
        check_eq("rst_after_mrd", LW'(mem_read), '0);
        check_eq("rst_after_mwr", LW'(mem_write), '0);
        check_eq("rst_after_drdy", LW'(d_ready), '0);
        d_read = 1'b0;
        settle();
        check_idle("idle_spur");

        // Withdrawn request during GRANT_D ignores mem_ready
        mem_ready = 1'b0; d_read = 1'b1;
        step(); settle();
        check_eq("wd_mrd", LW'(mem_read), 1);
        d_read = 1'b0; mem_ready = 1'b1;
        settle();
        check_eq("wd_drdy", LW'(d_ready), '0);
        step();
        d_read = 1'b1; mem_ready = 1'b0;
        settle();
        check_eq("wd_idle_mrd", LW'(mem_read), '0);

        // Read and write together while granted: write wins
        step();
        d_write = 1'b1;
        settle();
        check_eq("rw_mwr", LW'(mem_write), 1);
        check_eq("rw_mrd", LW'(mem_read), '0);
        mem_ready = 1'b1;
        settle();
        check_eq("rw_drdy", LW'(d_ready), 1);
        step();
        mem_ready = 1'b0; d_read = 1'b0; d_write = 1'b0;
        settle();
        check_idle("final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
